// File: rtl/cnn_frame_sequencer_if.sv
// Signal bundle between the host byte stream, the classifier core and the result consumer.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface cnn_frame_sequencer_if #(
    parameter int FRAME_W = 8
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        cnn_image;
    logic               cnn_start;
    logic               cnn_done;
    logic [3:0]         cnn_class;
    logic [3:0]         res_class;
    logic               res_timeout;
    logic               res_valid;
    logic               res_ready;
    logic [FRAME_W-1:0] frame_count;
    logic               busy;

    modport master (
        input  in_data, in_valid, cnn_done, cnn_class, res_ready,
        output in_ready, cnn_image, cnn_start, res_class, res_timeout,
               res_valid, frame_count, busy
    );

    modport slave (
        output in_data, in_valid, cnn_done, cnn_class, res_ready,
        input  in_ready, cnn_image, cnn_start, res_class, res_timeout,
               res_valid, frame_count, busy
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Assembles an 8x8 binary image from a byte stream, starts the classifier,
// waits for done (with timeout) and hands the class back over valid/ready.
module cnn_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FRAME_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_frame_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [63:0]        image_q, image_d;
    logic               start_q, start_d;
    logic [3:0]         res_class_q, res_class_d;
    logic               res_timeout_q, res_timeout_d;
    logic               res_valid_q, res_valid_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               armed_q, armed_d;
    logic [5:0]         byte_lsb;

    // Row k lands at bits [63-8k -: 8], i.e. LSB at 8*(7-k).
    assign byte_lsb = {3'd7 - byte_idx_q, 3'b000};

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        image_d       = image_q;
        start_d       = 1'b0;
        res_class_d   = res_class_q;
        res_timeout_d = res_timeout_q;
        res_valid_d   = res_valid_q;
        frame_count_d = frame_count_q;
        timer_d       = timer_q;
        armed_d       = armed_q;

        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    image_d[byte_lsb +: 8] = bus.in_data;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'd7) begin
                        state_d = START;
                        start_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
                timer_d = '0;
                armed_d = 1'b0;
            end
            WAIT: begin
                // A done level held over from the previous frame is only honoured after it drops.
                if (!bus.cnn_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && bus.cnn_done) begin
                    res_class_d   = bus.cnn_class;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = RESULT;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_class_d   = 4'hF;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = RESULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d   = 1'b0;
                    frame_count_d = frame_count_q + 1'b1;
                    state_d       = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            byte_idx_q    <= '0;
            image_q       <= '0;
            start_q       <= 1'b0;
            res_class_q   <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            frame_count_q <= '0;
            timer_q       <= '0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            image_q       <= image_d;
            start_q       <= start_d;
            res_class_q   <= res_class_d;
            res_timeout_q <= res_timeout_d;
            res_valid_q   <= res_valid_d;
            frame_count_q <= frame_count_d;
            timer_q       <= timer_d;
            armed_q       <= armed_d;
        end
    end

    assign bus.in_ready    = (state_q == LOAD);
    assign bus.busy        = (state_q != LOAD);
    assign bus.cnn_image   = image_q;
    assign bus.cnn_start   = start_q;
    assign bus.res_class   = res_class_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer with a short timeout and a 2-bit frame counter.
module tb_cnn_frame_sequencer;
    localparam int TO = 16;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cnn_frame_sequencer_if #(.FRAME_W(FW)) bus ();

    cnn_frame_sequencer #(.TIMEOUT_CYCLES(TO), .FRAME_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the 8 rows of img (row 0 first) with 'gap' idle cycles between bytes.
    // Returns just after the edge that accepted the 8th byte.
    task automatic load_frame(input logic [63:0] img, input int gap);
        logic [63:0] tmp;
        tmp = img;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tmp[63 - 8*k -: 8];
            tick();
            bus.in_valid = 1'b0;
            if (k < 7) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    // Keeps done low for n cycles, then a one-cycle done pulse carrying cls.
    task automatic pulse_done(input int n, input logic [3:0] cls);
        bus.cnn_done = 1'b0;
        for (int i = 0; i < n; i++) tick();
        bus.cnn_done  = 1'b1;
        bus.cnn_class = cls;
        tick();
        bus.cnn_done  = 1'b0;
        bus.cnn_class = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.cnn_image !== 64'h0) begin errors++; $display("[TB] FAIL reset_image: got %h expected 0", bus.cnn_image); end
        checks++; if ({bus.cnn_start, bus.res_valid, bus.res_timeout} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.cnn_start, bus.res_valid, bus.res_timeout}); end
        checks++; if (bus.res_class !== 4'h0 || bus.frame_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_result: got class=%h count=%0d expected 0/0", bus.res_class, bus.frame_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        for (int k = 0; k < 7; k++) tick();
        checks++; if (bus.cnn_start !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_early_start: got start=%b ready=%b expected 0/1", bus.cnn_start, bus.in_ready); end
        bus.in_data = 8'h80;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.cnn_start !== 1'b1) begin errors++; $display("[TB] FAIL basic_start: got %b expected 1", bus.cnn_start); end
        checks++; if (bus.cnn_image !== 64'h0000000000000080) begin errors++; $display("[TB] FAIL basic_image: got %h expected 0000000000000080", bus.cnn_image); end
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got busy=%b ready=%b expected 1/0", bus.busy, bus.in_ready); end
        pulse_done(9, 4'd3);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_class !== 4'd3 || bus.res_timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_result: got v=%b c=%h t=%b expected 1/3/0", bus.res_valid, bus.res_class, bus.res_timeout); end
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.frame_count !== 2'd1 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_handoff: got v=%b count=%0d ready=%b expected 0/1/1", bus.res_valid, bus.frame_count, bus.in_ready); end
    endtask

    task automatic test_stale_done();
        int bad;
        bus.cnn_done  = 1'b1;
        bus.cnn_class = 4'h9;
        load_frame(64'h00FF00FF00FF00FF, 1);
        checks++; if (bus.cnn_image !== 64'h00FF00FF00FF00FF || bus.cnn_start !== 1'b1) begin errors++; $display("[TB] FAIL gapped_image: got %h start=%b expected 00ff00ff00ff00ff/1", bus.cnn_image, bus.cnn_start); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stale_done: got %0d cycles with res_valid=1 expected 0", bad); end
        bus.cnn_done = 1'b0;
        tick();
        pulse_done(1, 4'd7);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_class !== 4'd7) begin errors++; $display("[TB] FAIL rearmed_done: got v=%b c=%h expected 1/7", bus.res_valid, bus.res_class); end
        tick();
        checks++; if (bus.frame_count !== 2'd2) begin errors++; $display("[TB] FAIL count_after_2: got %0d expected 2", bus.frame_count); end
    endtask

    task automatic test_timeout_and_hold();
        int cyc;
        int bad_ready;
        int bad_hold;
        bus.res_ready = 1'b0;
        bus.cnn_done  = 1'b0;
        load_frame(64'hA55AC33C0FF01248, 0);
        cyc = 0;
        bad_ready = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.in_ready !== 1'b0) bad_ready++;
        end
        checks++; if (cyc != TO + 1) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles after start expected %0d", cyc, TO + 1); end
        checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL wait_in_ready: got %0d cycles with in_ready=1 expected 0", bad_ready); end
        checks++; if (bus.res_class !== 4'hF || bus.res_timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_result: got c=%h t=%b expected f/1", bus.res_class, bus.res_timeout); end
        bad_hold = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            bus.cnn_done  = ~bus.cnn_done;
            bus.cnn_class = 4'd2;
            tick();
            if (bus.res_valid !== 1'b1 || bus.res_class !== 4'hF || bus.res_timeout !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.frame_count !== 2'd2) bad_hold++;
        end
        checks++; if (bad_hold != 0) begin errors++; $display("[TB] FAIL result_hold: got %0d disturbed cycles expected 0", bad_hold); end
        bus.in_valid  = 1'b0;
        bus.cnn_done  = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.frame_count !== 2'd3) begin errors++; $display("[TB] FAIL timeout_handoff: got v=%b count=%0d expected 0/3", bus.res_valid, bus.frame_count); end
        checks++; if (bus.cnn_image !== 64'hA55AC33C0FF01248) begin errors++; $display("[TB] FAIL image_held: got %h expected a55ac33c0ff01248", bus.cnn_image); end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h11 * (k + 1));
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.cnn_image !== 64'h0 || bus.frame_count !== 2'd0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midframe_reset: got img=%h count=%0d ready=%b expected 0/0/1", bus.cnn_image, bus.frame_count, bus.in_ready); end
        tick();
        checks++; if (bus.cnn_start !== 1'b0) begin errors++; $display("[TB] FAIL midframe_no_start: got %b expected 0", bus.cnn_start); end
        load_frame(64'h0102030405060708, 0);
        checks++; if (bus.cnn_image !== 64'h0102030405060708 || bus.cnn_start !== 1'b1) begin errors++; $display("[TB] FAIL new_frame: got %h start=%b expected 0102030405060708/1", bus.cnn_image, bus.cnn_start); end
        pulse_done(3, 4'd5);
        checks++; if (bus.res_class !== 4'd5 || bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL new_frame_class: got c=%h v=%b expected 5/1", bus.res_class, bus.res_valid); end
        tick();
        checks++; if (bus.frame_count !== 2'd1) begin errors++; $display("[TB] FAIL count_after_reset: got %0d expected 1", bus.frame_count); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_count;
        exp_count = 2'd1;
        for (int f = 0; f < 3; f++) begin
            load_frame({8{8'(f + 8'hC0)}}, 0);
            pulse_done(3, 4'(f + 10));
            checks++; if (bus.res_class !== 4'(f + 10)) begin errors++; $display("[TB] FAIL b2b_class: got %h expected %h", bus.res_class, 4'(f + 10)); end
            tick();
            exp_count = exp_count + 2'd1;
            checks++; if (bus.frame_count !== exp_count) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", bus.frame_count, exp_count); end
        end
        checks++; if (bus.frame_count !== 2'd0) begin errors++; $display("[TB] FAIL count_wrap: got %0d expected 0", bus.frame_count); end
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.cnn_done  = 1'b0;
        bus.cnn_class = 4'h0;
        bus.res_ready = 1'b1;
        test_reset();
        test_basic_frame();
        test_stale_done();
        test_timeout_and_hold();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
